// File: rtl/uart_cmd_parser.sv
// Byte-stream command decoder: assembles 'W'/'R' frames from UART bytes into 32-bit commands.
// Optional inter-byte timeout is enabled with `define UART_CMD_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_cmd_parser #(
   parameter int unsigned P_TIMEOUT_CYC = 1000000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_rx_vld,
   input  logic [7:0]  i_rx_dat,
   input  logic        i_rx_stpbt_err,
   output logic        o_cmd_vld,
   input  logic        i_cmd_rdy,
   output logic        o_cmd_wr,
   output logic [31:0] o_cmd_addr,
   output logic [31:0] o_cmd_wdat,
   output logic        o_busy,
   output logic        o_err_hdr,
   output logic        o_err_stpbt,
   output logic        o_err_ovr,
   output logic        o_err_tmo
);

   localparam int unsigned TMO_W  = 24;
   localparam logic [7:0]  HDR_WR = 8'h57;
   localparam logic [7:0]  HDR_RD = 8'h52;

   if (P_TIMEOUT_CYC < 2 || P_TIMEOUT_CYC > 32'h00FF_FFFF) begin : g_cfg_err
      $error("uart_cmd_parser: P_TIMEOUT_CYC out of range 2..2^24-1");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_CMD} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        wr_q, wr_d;
   logic        cmd_vld_q, busy_q;
   logic        err_hdr_q, err_hdr_d;
   logic        err_stpbt_q, err_stpbt_d;
   logic        err_ovr_q, err_ovr_d;
   logic        tmo_hit_c;

   logic rx_acc, rx_bad;
   assign rx_acc = i_rx_vld & ~i_rx_stpbt_err;
   assign rx_bad = i_rx_vld &  i_rx_stpbt_err;

`ifdef UART_CMD_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(P_TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_tmo_q;

   // Counter idles at 0 outside ADDR/DATA so entry always starts from zero; a byte beats expiry.
   always_comb begin
      tmo_d     = '0;
      tmo_hit_c = 1'b0;
      if (state_q == ST_ADDR || state_q == ST_DATA) begin
         if (i_rx_vld)
            tmo_d = '0;
         else if (tmo_q == TMO_MAX)
            tmo_hit_c = 1'b1;
         else
            tmo_d = tmo_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tmo_q     <= '0;
         err_tmo_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         err_tmo_q <= tmo_hit_c;
      end
   end

   assign o_err_tmo = err_tmo_q;
`else
   assign tmo_hit_c = 1'b0;
   assign o_err_tmo = 1'b0;
`endif

   // Frame assembly; command fields change only on accepted bytes outside ST_CMD.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdat_d      = wdat_q;
      wr_d        = wr_q;
      err_hdr_d   = 1'b0;
      err_stpbt_d = 1'b0;
      err_ovr_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_bad) begin
               err_stpbt_d = 1'b1;
            end else if (rx_acc) begin
               if (i_rx_dat == HDR_WR) begin
                  wr_d    = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_ADDR;
               end else if (i_rx_dat == HDR_RD) begin
                  wr_d    = 1'b0;
                  wdat_d  = '0;
                  cnt_d   = '0;
                  state_d = ST_ADDR;
               end else begin
                  err_hdr_d = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (rx_bad) begin
               err_stpbt_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (rx_acc) begin
               addr_d = {addr_q[23:0], i_rx_dat};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3)
                  state_d = wr_q ? ST_DATA : ST_CMD;
            end else if (tmo_hit_c) begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (rx_bad) begin
               err_stpbt_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (rx_acc) begin
               wdat_d = {wdat_q[23:0], i_rx_dat};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3)
                  state_d = ST_CMD;
            end else if (tmo_hit_c) begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            err_ovr_d = i_rx_vld;
            if (i_cmd_rdy)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdat_q      <= '0;
         wr_q        <= 1'b0;
         cmd_vld_q   <= 1'b0;
         busy_q      <= 1'b0;
         err_hdr_q   <= 1'b0;
         err_stpbt_q <= 1'b0;
         err_ovr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdat_q      <= wdat_d;
         wr_q        <= wr_d;
         cmd_vld_q   <= (state_d == ST_CMD);
         busy_q      <= (state_d != ST_IDLE);
         err_hdr_q   <= err_hdr_d;
         err_stpbt_q <= err_stpbt_d;
         err_ovr_q   <= err_ovr_d;
      end
   end

   assign o_cmd_vld   = cmd_vld_q;
   assign o_busy      = busy_q;
   assign o_cmd_wr    = wr_q;
   assign o_cmd_addr  = addr_q;
   assign o_cmd_wdat  = wdat_q;
   assign o_err_hdr   = err_hdr_q;
   assign o_err_stpbt = err_stpbt_q;
   assign o_err_ovr   = err_ovr_q;

endmodule
